// File: rtl/mux_sel_scheduler_if.sv
// mux_sel_scheduler_if: request/select/sample bundle between a 4:1 mux sampler and its client
interface mux_sel_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [3:0]       req;
    logic             mux_out;
    logic [1:0]       sel;
    logic             sel_valid;
    logic             sample;
    logic [1:0]       sample_ch;
    logic             sample_valid;
    logic [CNT_W-1:0] sample_count;

    modport master (
        output en, req, mux_out,
        input  sel, sel_valid, sample, sample_ch, sample_valid, sample_count
    );

    modport slave (
        input  en, req, mux_out,
        output sel, sel_valid, sample, sample_ch, sample_valid, sample_count
    );
endinterface

// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler: round-robin mux select driver with dwell hold and tagged capture
module mux_sel_scheduler #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    mux_sel_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARB, HOLD, CAP} state_t;
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;

    state_t           state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [1:0]       sel_q, sel_d, last_q, last_d, ch_q, ch_d;
    logic             sample_q, sample_d, sv_q, sv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rot;
    logic [1:0]       off, grant;
    logic             active, capture;

    assign active  = bus.en && |bus.req;
    // rotate requests so the channel after last_ch lands in bit 0
    assign rot     = {bus.req, bus.req} >> (last_q + 3'd1);
    assign off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign grant   = last_q + 2'd1 + off;
    assign capture = state_q == CAP && bus.en;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic; en low anywhere outside IDLE aborts to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = active ? ARB : IDLE;
            ARB:  state_d = active ? HOLD : IDLE;
            HOLD: state_d = !bus.en ? IDLE : dwell_q == '0 ? CAP : HOLD;
            CAP:  state_d = active ? ARB : IDLE;
        endcase
    end

    // datapath next values: sel moves only on ARB->HOLD, capture only on an enabled CAP
    always_comb begin
        sel_d    = state_q == ARB && active ? grant : sel_q;
        dwell_d  = state_q == ARB ? DW'(DWELL - 1) :
                   state_q == HOLD && dwell_q != '0 ? dwell_q - DW'(1) : dwell_q;
        sample_d = capture ? bus.mux_out : sample_q;
        ch_d     = capture ? sel_q : ch_q;
        last_d   = capture ? sel_q : last_q;
        sv_d     = capture;
        cnt_d    = capture && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // datapath registers; last_ch resets to 3 so the first grant scans from ch0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q  <= '0;
            sel_q    <= 2'd0;
            last_q   <= 2'd3;
            ch_q     <= 2'd0;
            sample_q <= 1'b0;
            sv_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            dwell_q  <= dwell_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            ch_q     <= ch_d;
            sample_q <= sample_d;
            sv_q     <= sv_d;
            cnt_q    <= cnt_d;
        end
    end

    // outputs; sel_valid follows the registered state so it never glitches
    always_comb begin
        bus.sel          = sel_q;
        bus.sel_valid    = state_q == HOLD || state_q == CAP;
        bus.sample       = sample_q;
        bus.sample_ch    = ch_q;
        bus.sample_valid = sv_q;
        bus.sample_count = cnt_q;
    end
endmodule

// File: tb/tb_mux_sel_scheduler.sv
// tb_mux_sel_scheduler: random and directed checks against a grant-phase reference model
module tb_mux_sel_scheduler;
    localparam int D = 4;

    logic       clk, rst_n, en;
    logic [3:0] req, abcd;
    int         errors = 0, checks = 0;

    mux_sel_scheduler_if #(.CNT_W(8)) bus8 ();
    mux_sel_scheduler_if #(.CNT_W(2)) bus2 ();

    assign bus8.en      = en;
    assign bus8.req     = req;
    assign bus8.mux_out = abcd[bus8.sel];
    assign bus2.en      = en;
    assign bus2.req     = req;
    assign bus2.mux_out = abcd[bus2.sel];

    mux_sel_scheduler #(.DWELL(D), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    mux_sel_scheduler #(.DWELL(D), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: a grant is a run of D+2 cycles, phase t=0 arb, 1..D hold, D+1 capture
    bit         m_busy, m_sv, m_sample;
    int         m_t, m_cnt;
    logic [1:0] m_sel, m_last, m_ch;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        for (int k = 1; k <= 4; k++)
            if (r[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
        return last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_t = 0; m_sv = 0; m_sample = 0; m_cnt = 0;
            m_sel = 2'd0; m_last = 2'd3; m_ch = 2'd0;
        end else begin
            m_sv = 0;
            if (!m_busy) begin
                if (en && req != 0) begin m_busy = 1; m_t = 0; end
            end else if (!en) m_busy = 0;
            else if (m_t == 0) begin
                if (req == 0) m_busy = 0;
                else begin m_sel = rr_pick(req, m_last); m_t = 1; end
            end else if (m_t <= D) m_t++;
            else begin
                m_sample = abcd[m_sel]; m_ch = m_sel; m_last = m_sel; m_sv = 1; m_cnt++;
                if (req != 0) m_t = 0; else m_busy = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("sel", 32'(bus8.sel), 32'(m_sel));
        chk("sel_valid", 32'(bus8.sel_valid), 32'(m_busy && m_t >= 1));
        chk("sample_valid", 32'(bus8.sample_valid), 32'(m_sv));
        chk("sample", 32'(bus8.sample), 32'(m_sample));
        chk("sample_ch", 32'(bus8.sample_ch), 32'(m_ch));
        chk("count8", 32'(bus8.sample_count), m_cnt > 255 ? 255 : m_cnt);
        chk("count2", 32'(bus2.sample_count), m_cnt > 3 ? 3 : m_cnt);
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_phase(input int t);
        int n = 0;
        while (!(m_busy && m_t == t) && n < 50) begin step(); n++; end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL wait_phase%0d: phase never reached", t);
        end
    endtask

    initial begin
        rst_n = 0; en = 0; req = 0; abcd = 0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1;
        en = 1; req = 4'hF; abcd = 4'b0101;
        repeat (32) step();
        chk("scan_count", 32'(bus8.sample_count), 32'd5);
        wait_phase(2);
        #2 rst_n = 0;
        #1 chk("rst_sel_valid", 32'(bus8.sel_valid), 32'd0);
        chk("rst_sample_valid", 32'(bus8.sample_valid), 32'd0);
        chk("rst_count", 32'(bus8.sample_count), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1;
        repeat (10) step();
        req = 4'b1001;
        repeat (40) step();
        req = 4'b0100;
        repeat (30) step();
        req = 4'hF;
        wait_phase(2);
        en = 0;
        repeat (2) step();
        en = 1;
        repeat (20) step();
        wait_phase(1);
        req = 4'b0000;
        repeat (10) step();
        req = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            step();
            en = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            abcd = 4'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 0;
                #1 check_all();
                @(negedge clk);
                check_all();
                rst_n = 1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
